spi_seq: RTL



---
 rtl/spi_seq_pkg.sv | 27 ++
 rtl/spi_seq_fifo.sv | 52 +++++
 rtl/spi_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared register map, bit positions and FSM state type for the SPI sequencer.
package spi_seq_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int unsigned CTRL_SS      = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_DIV_LSB = 4;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_TX_FULL  = 1;
  localparam int unsigned STAT_RX_EMPTY = 2;
  localparam int unsigned STAT_TX_OVF   = 3;
  localparam int unsigned STAT_RX_OVF   = 4;
  localparam int unsigned STAT_INT_PEND = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LO,
    HI,
    DONE
  } state_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous show-ahead FIFO with simultaneous push/pop; a push into a full
// FIFO is accepted only when a pop happens on the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_seq.sv
// Host-programmable SPI master sequencer: register decode, TX/RX FIFOs,
// mode-0 byte engine, chip-select sequencing and INT forwarding.
module spi_seq
  import spi_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  DIV_RESET  = 4'd3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] REG_ADDR,
  input  logic [7:0] REG_WDATA,
  input  logic       REG_WE,
  input  logic       REG_RE,
  output logic [7:0] REG_RDATA,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  input  logic       INT,
  output logic       IRQ
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t state, state_nx;

  logic       ctrl_ss, ctrl_ie;
  logic [3:0] ctrl_div;
  logic       tx_ovf, rx_ovf, int_pend;
  logic       ss_hold, ss_eff;
  logic [2:0] int_sync;
  logic       int_fall;

  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [3:0] hp_cnt;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] rx_count_unused;

  logic wr_data, wr_ctrl, wr_status, rd_data;
  logic tx_ovf_set, rx_ovf_set;
  logic load_go, sclk_rise, sclk_fall, last_bit, hp_run, busy;
  logic [7:0] status;

  assign wr_data   = REG_WE & (REG_ADDR == ADDR_DATA);
  assign wr_ctrl   = REG_WE & (REG_ADDR == ADDR_CTRL);
  assign wr_status = REG_WE & (REG_ADDR == ADDR_STATUS);
  assign rd_data   = REG_RE & (REG_ADDR == ADDR_DATA);

  assign tx_push    = wr_data & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop;
  assign rx_pop     = rd_data & ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (REG_WDATA),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (shift),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count_unused)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!tx_empty) state_nx = LOAD;
      LOAD: state_nx = LO;
      LO:   if (hp_cnt == '0) state_nx = HI;
      HI:   if (hp_cnt == '0) state_nx = (bit_cnt == '0) ? DONE : LO;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_pop     = (state == IDLE) & ~tx_empty;
    load_go    = (state == LOAD);
    sclk_rise  = (state == LO) & (hp_cnt == '0);
    sclk_fall  = (state == HI) & (hp_cnt == '0);
    last_bit   = (bit_cnt == '0);
    hp_run     = ((state == LO) | (state == HI)) & (hp_cnt != '0);
    rx_push    = (state == DONE) & ~rx_full;
    rx_ovf_set = (state == DONE) & rx_full;
    busy       = (state != IDLE) | (tx_count != '0);
  end

  // The shift register shifts on the rising edge, so after each rise shift[7]
  // is the next bit to drive and after eight rises it holds the received byte.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
      hp_cnt  <= '0;
    end else begin
      if (tx_pop) shift <= tx_rdata;
      if (load_go) begin
        MOSI    <= shift[7];
        bit_cnt <= 3'd7;
        hp_cnt  <= ctrl_div;
      end else if (sclk_rise) begin
        SCLK   <= 1'b1;
        shift  <= {shift[6:0], MISO};
        hp_cnt <= ctrl_div;
      end else if (sclk_fall) begin
        SCLK <= 1'b0;
        if (!last_bit) begin
          MOSI    <= shift[7];
          bit_cnt <= bit_cnt - 3'd1;
          hp_cnt  <= ctrl_div;
        end
      end else if (hp_run) begin
        hp_cnt <= hp_cnt - 4'd1;
      end
    end
  end

  // Chip select only tracks CTRL.ss while idle, so it is frozen for a whole byte.
  assign ss_eff   = (state == IDLE) ? ctrl_ss : ss_hold;
  assign SS       = ~ss_eff;
  assign int_fall = int_sync[2] & ~int_sync[1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_ss  <= 1'b0;
      ctrl_ie  <= 1'b0;
      ctrl_div <= DIV_RESET;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
      int_pend <= 1'b0;
      ss_hold  <= 1'b0;
      int_sync <= '1;
      IRQ      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_ss  <= REG_WDATA[CTRL_SS];
        ctrl_ie  <= REG_WDATA[CTRL_IE];
        ctrl_div <= REG_WDATA[CTRL_DIV_LSB +: 4];
      end
      tx_ovf   <= (tx_ovf & ~(wr_status & REG_WDATA[STAT_TX_OVF])) | tx_ovf_set;
      rx_ovf   <= (rx_ovf & ~(wr_status & REG_WDATA[STAT_RX_OVF])) | rx_ovf_set;
      int_pend <= (int_pend & ~(wr_status & REG_WDATA[STAT_INT_PEND])) | int_fall;
      ss_hold  <= ss_eff;
      int_sync <= {int_sync[1:0], INT};
      IRQ      <= int_pend & ctrl_ie;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = busy;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_TX_OVF]   = tx_ovf;
    status[STAT_RX_OVF]   = rx_ovf;
    status[STAT_INT_PEND] = int_pend;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      REG_RDATA <= '0;
    end else if (REG_RE) begin
      unique case (REG_ADDR)
        ADDR_DATA:   REG_RDATA <= rx_empty ? 8'hFF : rx_rdata;
        ADDR_CTRL:   REG_RDATA <= {ctrl_div, 2'b00, ctrl_ie, ctrl_ss};
        ADDR_STATUS: REG_RDATA <= status;
        default:     REG_RDATA <= '0;
      endcase
    end
  end

endmodule
